// File: rtl/imm_byte_splitter.sv
// Splits a 16-bit constant into two flagged 8-bit immediates over ready/valid.
// Optional macro IMM_SPLIT_SKIP_ZERO_EN suppresses zero bytes at word acceptance.
module imm_byte_splitter #(
  parameter int HI_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_valid,
  input  logic [15:0] word_in,
  output logic        word_ready,
  output logic        imm_valid,
  output logic [7:0]  imm,
  output logic        flag,
  output logic        imm_last,
  input  logic        imm_ready,
  output logic        busy
);

  localparam logic HF = (HI_FIRST != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] word_r, word_s;
  logic [7:0]  imm_r, imm_s;
  logic        flag_r, flag_s;
  logic        last_r, last_s;
  logic        valid_r, valid_s;
  logic        busy_r;

  logic        final_s;
  logic        accept_s;
  logic [7:0]  acc_imm_s;
  logic        acc_flag_s;
  logic        acc_last_s;

  // Handshake qualifiers; a single-byte FIRST behaves like SECOND on its handshake
  always_comb begin
    final_s    = (state_r == SECOND) || ((state_r == FIRST) && last_r);
    word_ready = !reset && ((state_r == IDLE) || (final_s && imm_ready));
    accept_s   = word_valid && word_ready;
  end

  // First byte presented for a word being accepted this cycle
  always_comb begin
    acc_imm_s  = HF ? word_in[15:8] : word_in[7:0];
    acc_flag_s = HF;
    acc_last_s = 1'b0;
`ifdef IMM_SPLIT_SKIP_ZERO_EN
    if (word_in == 16'h0000) begin
      acc_imm_s  = 8'h00;
      acc_flag_s = 1'b0;
      acc_last_s = 1'b1;
    end else if (word_in[15:8] == 8'h00) begin
      acc_imm_s  = word_in[7:0];
      acc_flag_s = 1'b0;
      acc_last_s = 1'b1;
    end else if (word_in[7:0] == 8'h00) begin
      acc_imm_s  = word_in[15:8];
      acc_flag_s = 1'b1;
      acc_last_s = 1'b1;
    end else begin
      acc_imm_s  = HF ? word_in[15:8] : word_in[7:0];
      acc_flag_s = HF;
      acc_last_s = 1'b0;
    end
`endif
  end

  // Next-state and next-output selection; everything holds unless a handshake occurs
  always_comb begin
    state_s = state_r;
    word_s  = word_r;
    imm_s   = imm_r;
    flag_s  = flag_r;
    last_s  = last_r;
    valid_s = valid_r;
    if (accept_s) begin
      state_s = FIRST;
      word_s  = word_in;
      valid_s = 1'b1;
      imm_s   = acc_imm_s;
      flag_s  = acc_flag_s;
      last_s  = acc_last_s;
    end else if ((state_r == FIRST) && !last_r && imm_ready) begin
      state_s = SECOND;
      imm_s   = HF ? word_r[7:0] : word_r[15:8];
      flag_s  = ~HF;
      last_s  = 1'b1;
    end else if (final_s && imm_ready) begin
      state_s = IDLE;
      valid_s = 1'b0;
    end else if ((state_r != IDLE) && (state_r != FIRST) && (state_r != SECOND)) begin
      // Unreachable encoding recovers to a clean idle
      state_s = IDLE;
      valid_s = 1'b0;
      last_s  = 1'b0;
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      word_r  <= 16'h0000;
      imm_r   <= 8'h00;
      flag_r  <= 1'b0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      imm_r   <= imm_s;
      flag_r  <= flag_s;
      last_r  <= last_s;
      valid_r <= valid_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  assign imm_valid = valid_r;
  assign imm       = imm_r;
  assign flag      = flag_r;
  assign imm_last  = last_r;
  assign busy      = busy_r;

endmodule

// File: doc/imm_byte_splitter.md
Name: imm_byte_splitter

Overview:
- Inverse of the immediate-placement stage: takes a 16-bit constant and emits it as two 8-bit immediates, each tagged with a flag.
- flag=1 marks the byte destined for [15:8]; flag=0 marks the byte destined for [7:0].
- Sits between the constant-generation logic and the 8-bit immediate bus, so wide constants reach the datapath as two narrow immediate writes.
- Buffered, ready/valid on both sides.

Parameters:
- HI_FIRST, 1, 1 = high byte (flag=1) emitted first; 0 = low byte (flag=0) emitted first.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- word_valid  input  1  16-bit word offered
- word_in  input  16  constant to split
- word_ready  output  1  splitter accepts word this cycle
- imm_valid  output  1  byte on imm/flag is valid
- imm  output  8  immediate byte
- flag  output  1  1 = high byte, 0 = low byte
- imm_last  output  1  current byte is the final byte of its word
- imm_ready  input  1  downstream accepts byte this cycle
- busy  output  1  a word is held, i.e. state != IDLE

Behaviour:
- Reset is synchronous, active-high, and sampled on the clk rising edge. While reset is high:
  - state <= IDLE
  - imm_valid, imm, flag, imm_last, busy, and the held word all <= 0
  - word_ready = 0 (combinationally gated by reset)
- Reset mid-operation discards the held word and any byte not yet handshaked. imm_valid is 0 from the first edge with reset high.
- States:
  - IDLE: no word held.
  - FIRST: first byte presented.
  - SECOND: second byte presented.
- word_ready = !reset && (state==IDLE || (state==SECOND && imm_ready)).
- Word handshake: word_valid && word_ready at an edge latches word_in and moves to FIRST. At that same edge, outputs are registered as:
  - imm_valid <= 1
  - imm <= first byte (word_in[15:8] if HI_FIRST, else word_in[7:0])
  - flag <= HI_FIRST
  - imm_last <= 0
- Latency: a word accepted at edge N has its first byte valid in the cycle after N; no combinational path from word_in to imm.
- FIRST with imm_ready=1 at an edge:
  - State -> SECOND.
  - imm <= the other byte; flag <= !HI_FIRST; imm_last <= 1.
- SECOND with imm_ready=1 at an edge:
  - If word_valid is also high, the new word is accepted at that edge and the state goes directly to FIRST with its first byte. This gives back-to-back throughput of 1 byte/cycle with no bubble.
  - Otherwise the state goes to IDLE and imm_valid <= 0.
- Output stability: while imm_valid=1 and imm_ready=0, imm, flag, imm_last and the state all hold unchanged.
- word_in changes while not accepted are ignored; only the latched copy is used.
- busy = (state != IDLE), registered with the state.
- Simultaneous reset and handshakes: reset wins; no word is accepted and no byte is consumed.
- imm_ready while imm_valid=0 has no effect.

Optional Feature:
- Macro: IMM_SPLIT_SKIP_ZERO_EN.
- Defined:
  - At word acceptance, any byte equal to 8'h00 is not emitted, since the placement stage zero-fills the other half.
  - If exactly one byte is nonzero, only that byte is emitted: FIRST carries it with the correct flag and imm_last=1, and its handshake goes to IDLE. The chained-accept rule of SECOND applies to that handshake too.
  - If both bytes are zero, a single low byte (imm=8'h00, flag=0, imm_last=1) is emitted.
  - Order among two nonzero bytes follows HI_FIRST.
- Undefined: both bytes are always emitted, as described in Behaviour.

Test Plan:
- Reset then idle -> imm_valid=0, imm=8'h00, flag=0, busy=0, word_ready=0 during reset and 1 the cycle after reset deasserts.
- HI_FIRST=1, word 16'hA55A, imm_ready=1 -> cycle+1: imm=8'hA5 flag=1 last=0; cycle+2: imm=8'h5A flag=1'b0 last=1; cycle+3: imm_valid=0.
- HI_FIRST=0, word 16'h1234, imm_ready held 0 for 3 cycles then 1 -> imm=8'h34 flag=0 stable for all stall cycles; then imm=8'h12 flag=1 last=1.
- Back-to-back words 16'h0102, 16'h0304, word_valid and imm_ready always 1 -> bytes 01,02,03,04 on consecutive cycles, flags 1,0,1,0, no bubble.
- Reset asserted while in SECOND with imm_ready=0 -> next cycle imm_valid=0 and busy=0; a subsequent word 16'hBEEF emits BE then EF cleanly.
- IMM_SPLIT_SKIP_ZERO_EN defined:
  - word 16'h00C3 -> single byte 8'hC3, flag=0, last=1.
  - word 16'h0000 -> single byte 8'h00, flag=0, last=1.
  - word 16'h7F00 -> single byte 8'h7F, flag=1, last=1.
